// File: rtl/fechadura_pkg.sv
// Shared types and helpers for the digital lock: PIN packet layout,
// verifier state encoding and the digit-range check.
package fechadura_pkg;

    localparam logic [3:0]  KEY_SEND    = 4'hE;
    localparam logic [15:0] INVALID_PIN = 16'hFFFF;

    typedef struct packed {
        logic       status;
        logic [3:0] digit4;
        logic [3:0] digit3;
        logic [3:0] digit2;
        logic [3:0] digit1;
    } pinPac_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CHECK   = 2'd1,
        ST_OPEN    = 2'd2,
        ST_LOCKOUT = 2'd3
    } verif_state_t;

    // A PIN is usable only when every nibble is a decimal digit.
    function automatic logic pin_is_valid(input logic [15:0] pin);
        return (pin[15:12] <= 4'd9) && (pin[11:8] <= 4'd9) &&
               (pin[7:4]   <= 4'd9) && (pin[3:0]  <= 4'd9);
    endfunction

endpackage

// File: rtl/detector_borda.sv
// Single-bit rising-edge detector; the edge output is combinational from
// the live input and the registered previous sample.
module detector_borda (
    input  logic clk,
    input  logic rst,
    input  logic i_sig,
    output logic o_edge
);

    logic r_sig_d1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_sig_d1 <= 1'b0;
        else     r_sig_d1 <= i_sig;
    end

    assign o_edge = i_sig & ~r_sig_d1;

endmodule

// File: rtl/verifica_senha.sv
// PIN verifier: compares sent PINs against the stored password, drives the
// door, enforces the attempt limit and lets an open door change the password.
//
// state      | meaning
// ST_IDLE    | waiting for a new PIN packet
// ST_CHECK   | one cycle comparing the captured PIN
// ST_OPEN    | door unlocked, open timer running, next valid PIN replaces password
// ST_LOCKOUT | attempts exhausted, packets ignored until the timer expires
module verifica_senha
    import fechadura_pkg::*;
#(
    parameter logic [15:0] DEFAULT_PIN    = 16'h1234,
    parameter int          MAX_TRIES      = 3,
    parameter int          UNLOCK_CYCLES  = 50_000_000,
    parameter int          LOCKOUT_CYCLES = 500_000_000
) (
    input  logic                               clk,
    input  logic                               rst,
    input  pinPac_t                            pin_in,
    output logic                               door_open,
    output logic                               pin_ok,
    output logic                               pin_fail,
    output logic                               pin_changed,
    output logic                               locked_out,
    output logic [$clog2(MAX_TRIES+1)-1:0]     tries_left
);

    localparam int CNT_MAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam int TRY_W   = $clog2(MAX_TRIES + 1);

    localparam logic [CNT_W-1:0] OPEN_LOAD = CNT_W'(UNLOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LOAD = CNT_W'(LOCKOUT_CYCLES - 1);
    localparam logic [TRY_W-1:0] TRIES_MAX = TRY_W'(MAX_TRIES);

    verif_state_t     r_state;
    logic [15:0]      r_stored_pin;
    logic [15:0]      r_pin_reg;
    logic [CNT_W-1:0] r_timer;
    logic             w_new_pkt;
    logic [15:0]      w_pin;

    assign w_pin = {pin_in.digit4, pin_in.digit3, pin_in.digit2, pin_in.digit1};

    detector_borda u_borda (
        .clk    (clk),
        .rst    (rst),
        .i_sig  (pin_in.status),
        .o_edge (w_new_pkt)
    );

    // Timer is loaded with count-1 so the terminal compare at zero lands on
    // the last cycle of the window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_stored_pin <= DEFAULT_PIN;
            r_pin_reg    <= '0;
            r_timer      <= '0;
            door_open    <= 1'b0;
            pin_ok       <= 1'b0;
            pin_fail     <= 1'b0;
            pin_changed  <= 1'b0;
            locked_out   <= 1'b0;
            tries_left   <= TRIES_MAX;
        end else begin
            pin_ok      <= 1'b0;
            pin_fail    <= 1'b0;
            pin_changed <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_new_pkt) begin
                        r_pin_reg <= w_pin;
                        r_state   <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if ((r_pin_reg == r_stored_pin) && pin_is_valid(r_pin_reg)) begin
                        pin_ok     <= 1'b1;
                        tries_left <= TRIES_MAX;
                        door_open  <= 1'b1;
                        r_timer    <= OPEN_LOAD;
                        r_state    <= ST_OPEN;
                    end else begin
                        pin_fail <= 1'b1;
                        if (tries_left > TRY_W'(1)) begin
                            tries_left <= tries_left - TRY_W'(1);
                            r_state    <= ST_IDLE;
                        end else begin
                            tries_left <= '0;
                            locked_out <= 1'b1;
                            r_timer    <= LOCK_LOAD;
                            r_state    <= ST_LOCKOUT;
                        end
                    end
                end
                ST_OPEN: begin
                    if (w_new_pkt && pin_is_valid(w_pin)) begin
                        r_stored_pin <= w_pin;
                        pin_changed  <= 1'b1;
                        door_open    <= 1'b0;
                        r_state      <= ST_IDLE;
                    end else begin
                        if (w_new_pkt) pin_fail <= 1'b1;
                        if (r_timer == '0) begin
                            door_open <= 1'b0;
                            r_state   <= ST_IDLE;
                        end else begin
                            r_timer <= r_timer - CNT_W'(1);
                        end
                    end
                end
                ST_LOCKOUT: begin
                    if (r_timer == '0) begin
                        locked_out <= 1'b0;
                        tries_left <= TRIES_MAX;
                        r_state    <= ST_IDLE;
                    end else begin
                        r_timer <= r_timer - CNT_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_verifica_senha.sv
// Bench for verifica_senha: a timeline model predicts pulses (queued) and
// per-cycle levels; a negedge monitor pops and compares.
module tb_verifica_senha;
    import fechadura_pkg::*;

    localparam int          U    = 8;
    localparam int          L    = 16;
    localparam int          MAXT = 3;
    localparam int          NCYC = 4096;
    localparam logic [15:0] DEF  = 16'h1234;
    localparam int          K_OK = 0, K_FAIL = 1, K_CHG = 2;

    typedef struct { int kind; int cyc; int ep; } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    pinPac_t    pin_in = '0;
    logic       door_open, pin_ok, pin_fail, pin_changed, locked_out;
    logic [1:0] tries_left;

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          epoch = 0;
    logic [15:0] m_stored = DEF;
    int          m_check = -1;
    bit          m_prev = 1'b0;
    bit          exp_door [NCYC];
    bit          exp_lock [NCYC];
    int          exp_tries[NCYC];
    ev_t         exp_q[$];

    verifica_senha #(
        .DEFAULT_PIN(DEF), .MAX_TRIES(MAXT), .UNLOCK_CYCLES(U), .LOCKOUT_CYCLES(L)
    ) dut (
        .clk(clk), .rst(rst), .pin_in(pin_in), .door_open(door_open), .pin_ok(pin_ok),
        .pin_fail(pin_fail), .pin_changed(pin_changed), .locked_out(locked_out),
        .tries_left(tries_left)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic bit digits_ok(input logic [15:0] p);
        for (int i = 0; i < 4; i++)
            if (p[4*i +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    task automatic set_lvl(input int which, input int from, input int to, input int v);
        for (int n = from; n <= to && n < NCYC; n++) begin
            case (which)
                0:       exp_door[n]  = (v != 0);
                1:       exp_lock[n]  = (v != 0);
                default: exp_tries[n] = v;
            endcase
        end
    endtask

    task automatic push_ev(input int k, input int c);
        ev_t e;
        e.kind = k; e.cyc = c; e.ep = epoch;
        exp_q.push_back(e);
    endtask

    // Timeline model: a packet first seen in cycle t is judged by the mode
    // the lock is in during t; consequences are written into future cycles.
    task automatic model_pkt(input int t, input logic [15:0] p);
        bit ok;
        int tr;
        ok = digits_ok(p);
        if (t == m_check) return;
        if (exp_door[t]) begin
            if (ok) begin
                m_stored = p;
                push_ev(K_CHG, t + 1);
                set_lvl(0, t + 1, NCYC - 1, 0);
            end else begin
                push_ev(K_FAIL, t + 1);
            end
            return;
        end
        if (exp_lock[t]) return;
        m_check = t + 1;
        if (ok && p == m_stored) begin
            push_ev(K_OK, t + 2);
            set_lvl(2, t + 2, NCYC - 1, MAXT);
            set_lvl(0, t + 2, t + 1 + U, 1);
        end else begin
            push_ev(K_FAIL, t + 2);
            tr = exp_tries[t + 1] - 1;
            set_lvl(2, t + 2, NCYC - 1, tr);
            if (tr == 0) begin
                set_lvl(1, t + 2, t + 1 + L, 1);
                set_lvl(2, t + 2 + L, NCYC - 1, MAXT);
            end
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d, expected %0d", nm, cyc, act, exp_v);
        end
    endtask

    task automatic pulse(input int k, input string nm);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s cycle %0d: got unexpected pulse, expected none", nm, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.cyc != cyc) begin
                errors++;
                $display("FAIL %s cycle %0d: got pulse kind %0d, expected kind %0d at cycle %0d",
                         nm, cyc, k, e.kind, e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (cyc > 0 && cyc < NCYC) begin
            while (exp_q.size() > 0 && exp_q[0].ep != epoch) void'(exp_q.pop_front());
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL missed_pulse cycle %0d: got nothing, expected kind %0d at cycle %0d",
                         cyc, exp_q[0].kind, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            chk("door_open", int'(door_open), int'(exp_door[cyc]));
            chk("locked_out", int'(locked_out), int'(exp_lock[cyc]));
            chk("tries_left", int'(tries_left), exp_tries[cyc]);
            if (pin_ok)      pulse(K_OK, "pin_ok");
            if (pin_fail)    pulse(K_FAIL, "pin_fail");
            if (pin_changed) pulse(K_CHG, "pin_changed");
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit s, input logic [15:0] p);
        pin_in = {s, p};
        if (s && !m_prev && !rst) model_pkt(cyc, p);
        m_prev = s;
        tick();
    endtask

    task automatic send(input logic [15:0] p);
        drive(1'b1, p);
        drive(1'b1, p);
        drive(1'b0, p);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 16'h0000);
    endtask

    task automatic do_reset();
        pin_in = '0;
        m_prev = 1'b0;
        rst = 1'b1;
        epoch++;
        m_stored = DEF;
        m_check = -1;
        set_lvl(0, cyc, NCYC - 1, 0);
        set_lvl(1, cyc, NCYC - 1, 0);
        set_lvl(2, cyc, NCYC - 1, MAXT);
        #1;
        chk("rst_door_open", int'(door_open), 0);
        chk("rst_locked_out", int'(locked_out), 0);
        chk("rst_tries_left", int'(tries_left), MAXT);
        chk("rst_pulses", int'({pin_ok, pin_fail, pin_changed}), 0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [15:0] p;
        int          r;
        int          left;
        for (int n = 0; n < NCYC; n++) begin
            exp_door[n] = 1'b0; exp_lock[n] = 1'b0; exp_tries[n] = MAXT;
        end
        repeat (3) tick();
        chk("init_tries_left", int'(tries_left), MAXT);
        chk("init_door_open", int'(door_open), 0);
        rst = 1'b0;
        idle(3);

        send(16'h1234);  idle(12);
        send(16'h1111);  idle(2);
        send(16'h1111);  idle(2);
        send(16'h1111);  idle(3);
        send(16'h1234);  idle(20);

        send(16'h1234);  idle(3);
        send(16'h4321);  idle(3);
        send(16'h1234);  idle(3);
        send(16'h4321);  idle(12);

        send(16'h4321);  idle(2);
        send(INVALID_PIN); idle(12);

        repeat (4) drive(1'b1, 16'h1111);
        repeat (4) drive(1'b1, 16'h1111);
        idle(4);

        send(16'h4321);  idle(3);
        do_reset();
        idle(2);
        send(16'h1111);  idle(2);
        send(16'h1111);  idle(2);
        send(16'h1111);  idle(5);
        do_reset();
        idle(2);
        send(16'h1234);  idle(12);

        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2: p = m_stored;
                3, 4:    p = 16'h1111;
                5:       p = INVALID_PIN;
                6:       p = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                              4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
                7:       p = 16'($urandom);
                default: p = 16'h4321;
            endcase
            repeat ($urandom_range(1, 3)) drive(1'b1, p);
            repeat ($urandom_range(0, 4)) drive(1'b0, p);
            if ($urandom_range(0, 40) == 0) do_reset();
        end

        idle(30);
        left = 0;
        foreach (exp_q[i]) if (exp_q[i].ep == epoch) left++;
        chk("pending_pulses", left, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
